// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, plus an
// automatic load-and-serial-out sequence. Define USR_ROTATE_EN to rotate instead of filling from sin.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, done_reg;
  logic             fill_bit;

`ifdef USR_ROTATE_EN
  assign fill_bit = q_reg[0];
`else
  assign fill_bit = sin;
`endif

  // State register; en gates every update so a paused sequence loses no bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next   = d;
          cnt_next = CNT_W'(WIDTH);
        end else begin
          case (mode)
            2'b01:   q_next = {sin, q_reg[WIDTH-1:1]};
            2'b10:   q_next = {q_reg[WIDTH-2:0], sin};
            2'b11:   q_next = d;
            default: q_next = q_reg;
          endcase
        end
      end
      SHIFT: begin
        q_next   = {fill_bit, q_reg[WIDTH-1:1]};
        cnt_next = cnt_reg - CNT_W'(1);
      end
      default: begin
        q_next   = q_reg;
        cnt_next = cnt_reg;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (en) begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
    end
  end

  assign q    = q_reg;
  assign sout = q_reg[0];
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8): directed stimulus pushes
// hand-computed expectations, a monitor process pops and compares them.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       start;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .start (start),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  // q after load (index 0) and after each of the 8 automatic shifts of d=B4, sin=0.
  logic [7:0] seq_q [0:8];

  task automatic expect_out(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.name = name;
    e.q    = eq;
    e.sout = eq[0];
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
    ->chk_ev;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares pending expectations against the live outputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({q, sout, busy, done} !== {e.q, e.sout, e.busy, e.done}) begin
          errors++;
          $display("FAIL %s: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%b busy=%b done=%b",
                   e.name, q, sout, busy, done, e.q, e.sout, e.busy, e.done);
        end else begin
          $display("ok   %s: q=%h sout=%b busy=%b done=%b", e.name, q, sout, busy, done);
        end
      end
    end
  end

  task automatic run_full(input string tag);
    en = 1'b1; start = 1'b1; mode = 2'b11; d = 8'hB4; sin = 1'b0;
    step();
    expect_out({tag, " load"}, seq_q[0], 1'b1, 1'b0);
    start = 1'b0; mode = 2'b11; d = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_out($sformatf("%s shift%0d", tag, i), seq_q[i], 1'b1, (i == 8));
    end
    mode = 2'b00;
    step();
    expect_out({tag, " back_idle"}, seq_q[8], 1'b0, 1'b0);
  endtask

  initial begin : stim
`ifdef USR_ROTATE_EN
    seq_q[0] = 8'hB4; seq_q[1] = 8'h5A; seq_q[2] = 8'h2D; seq_q[3] = 8'h96; seq_q[4] = 8'h4B;
    seq_q[5] = 8'hA5; seq_q[6] = 8'hD2; seq_q[7] = 8'h69; seq_q[8] = 8'hB4;
`else
    seq_q[0] = 8'hB4; seq_q[1] = 8'h5A; seq_q[2] = 8'h2D; seq_q[3] = 8'h16; seq_q[4] = 8'h0B;
    seq_q[5] = 8'h05; seq_q[6] = 8'h02; seq_q[7] = 8'h01; seq_q[8] = 8'h00;
`endif

    // Reset with unknown control/data inputs.
    rst_n = 1'b0; en = 1'b1; mode = 2'bxx; start = 1'bx; d = 8'hxx; sin = 1'bx;
    #1;
    expect_out("reset_t0", 8'h00, 1'b0, 1'b0);
    step();
    expect_out("reset_x_edge1", 8'h00, 1'b0, 1'b0);
    step();
    expect_out("reset_x_edge2", 8'h00, 1'b0, 1'b0);
    mode = 2'b00; start = 1'b0; d = 8'h00; sin = 1'b0;
    #2 rst_n = 1'b1;

    // Manual modes.
    mode = 2'b11; d = 8'hA5;
    step(); expect_out("load_A5", 8'hA5, 1'b0, 1'b0);
    mode = 2'b01; sin = 1'b1;
    step(); expect_out("shr_sin1", 8'hD2, 1'b0, 1'b0);
    mode = 2'b10; sin = 1'b0;
    step(); expect_out("shl_sin0", 8'hA4, 1'b0, 1'b0);
    mode = 2'b00;
    step(); expect_out("hold", 8'hA4, 1'b0, 1'b0);
    en = 1'b0; mode = 2'b11; d = 8'hFF; start = 1'b1;
    step(); expect_out("en_low_hold", 8'hA4, 1'b0, 1'b0);
    start = 1'b0; mode = 2'b00;

    // Full automatic sequence, start has priority over mode=11.
    run_full("seq");

    // Pause for 3 cycles after the 4th shift, with start pulses while busy.
    en = 1'b1; start = 1'b1; mode = 2'b00; d = 8'hB4; sin = 1'b0;
    step(); expect_out("pause load", seq_q[0], 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(); expect_out($sformatf("pause shift%0d", i), seq_q[i], 1'b1, 1'b0);
    end
    en = 1'b0; start = 1'b1; d = 8'h77;
    for (int i = 1; i <= 3; i++) begin
      step(); expect_out($sformatf("paused%0d", i), seq_q[4], 1'b1, 1'b0);
    end
    en = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      step(); expect_out($sformatf("pause shift%0d", i), seq_q[i], 1'b1, (i == 8));
      start = 1'b0;
    end
    en = 1'b0;
    step(); expect_out("done_held_en0", seq_q[8], 1'b1, 1'b1);
    en = 1'b1; start = 1'b1;
    step(); expect_out("done_to_idle_start_ignored", seq_q[8], 1'b0, 1'b0);
    start = 1'b0;
    step(); expect_out("no_queued_start", seq_q[8], 1'b0, 1'b0);

    // Reset after the 5th shift.
    start = 1'b1; d = 8'hB4;
    step(); expect_out("abort load", seq_q[0], 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(); expect_out($sformatf("abort shift%0d", i), seq_q[i], 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    step(); expect_out("reset_held", 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(); expect_out($sformatf("post_reset_idle%0d", i), 8'h00, 1'b0, 1'b0);
    end
    mode = 2'b11; d = 8'h5A;
    step(); expect_out("post_reset_load", 8'h5A, 1'b0, 1'b0);
    run_full("restart");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
